// File: rtl/bus_debug_master_pkg.sv
// Shared constants for the byte-stream debug bus master: command opcodes,
// response codes and the controller state encoding.
package bus_debug_master_pkg;

    // Command opcodes received on the byte source
    localparam logic [7:0] OP_WR   = 8'h57;  // 'W' + addr[4] + data[4]
    localparam logic [7:0] OP_RD   = 8'h52;  // 'R' + addr[4]
    localparam logic [7:0] OP_PING = 8'h50;  // 'P'

    // Single-byte response codes sent to the byte sink
    localparam logic [7:0] RSP_ACK  = 8'h06;  // write completed
    localparam logic [7:0] RSP_NAK  = 8'h15;  // unknown opcode
    localparam logic [7:0] RSP_TMO  = 8'h18;  // bus request timed out
    localparam logic [7:0] RSP_PING = 8'h50;  // ping echo

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_BUS  = 3'd3,
        ST_RESP = 3'd4
    } state_e;

endpackage

// File: rtl/bus_debug_master.sv
// Debug bus initiator: parses 'W'/'R'/'P' commands from a byte stream,
// runs one single-word bus cycle per command and streams the response back.
//
// Handshakes:
//   RX   : RX_VALID is a one-cycle strobe with no back-pressure; bytes that
//          arrive while a bus cycle or response is in progress are discarded
//          and flagged with a one-cycle DROP pulse.
//   TX   : TX_DATA is transferred on every rising edge where TX_VALID and
//          TX_READY are both high; TX_VALID/TX_DATA stay stable until then.
//   Bus  : XDREQ stays high with XADDR/XATAO/XBE/XRD/XWR stable until the
//          responder returns XDACK (XATAI valid in that cycle) or the request
//          times out; XDREQ drops on the following edge.
module bus_debug_master
    import bus_debug_master_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int TOW     = 10
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY,
    output logic        XDREQ,
    output logic        XRD,
    output logic        XWR,
    output logic [3:0]  XBE,
    output logic [31:0] XADDR,
    output logic [31:0] XATAO,
    input  logic [31:0] XATAI,
    input  logic        XDACK,
    output logic        BUSY,
    output logic        DROP
);

    state_e           state_q, state_d;
    logic [7:0]       op_q, op_d;          // opcode of the command in flight
    logic [1:0]       cnt_q, cnt_d;        // byte index in ADDR/DATA/RESP
    logic [1:0]       last_q, last_d;      // index of the final response byte
    logic [31:0]      shift_q, shift_d;    // LSB-first byte shift-in
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;    // response bytes, shifted out LSB first
    logic [TOW-1:0]   tmo_q, tmo_d;
    logic             xdreq_q, xdreq_d;
    logic             xrd_q, xrd_d;
    logic             xwr_q, xwr_d;
    logic [3:0]       xbe_q, xbe_d;
    logic             tx_valid_q, tx_valid_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             busy_q, busy_d;
    logic             drop_q, drop_d;
    logic [31:0]      shift_in;

    // Next-state and next-output computation for the command controller
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        tmo_d      = tmo_q;
        xdreq_d    = xdreq_q;
        xrd_d      = xrd_q;
        xwr_d      = xwr_q;
        xbe_d      = xbe_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        drop_d     = 1'b0;
        shift_in   = {RX_DATA, shift_q[31:8]};

        case (state_q)
            ST_IDLE: begin
                if (RX_VALID) begin
                    cnt_d = 2'd0;
                    if (RX_DATA == OP_WR || RX_DATA == OP_RD) begin
                        op_d    = RX_DATA;
                        state_d = ST_ADDR;
                    end else begin
                        // Ping and unknown opcodes answer with one byte
                        rdata_d = {24'h0, (RX_DATA == OP_PING) ? RSP_PING : RSP_NAK};
                        last_d  = 2'd0;
                        state_d = ST_RESP;
                    end
                end
            end

            ST_ADDR: begin
                if (RX_VALID) begin
                    shift_d = shift_in;
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        // Bus is word-addressed: low address bits are dropped
                        addr_d = {shift_in[31:2], 2'b00};
                        if (op_q == OP_WR) begin
                            state_d = ST_DATA;
                        end else begin
                            state_d = ST_BUS;
                            xdreq_d = 1'b1;
                            xrd_d   = 1'b1;
                            xwr_d   = 1'b0;
                            xbe_d   = 4'hF;
                            tmo_d   = '0;
                        end
                    end
                end
            end

            ST_DATA: begin
                if (RX_VALID) begin
                    shift_d = shift_in;
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        wdata_d = shift_in;
                        state_d = ST_BUS;
                        xdreq_d = 1'b1;
                        xrd_d   = 1'b0;
                        xwr_d   = 1'b1;
                        xbe_d   = 4'hF;
                        tmo_d   = '0;
                    end
                end
            end

            ST_BUS: begin
                drop_d = RX_VALID;
                // Acknowledge takes priority over a timeout in the same cycle
                if (XDACK || tmo_q == TOW'(TIMEOUT - 1)) begin
                    xdreq_d = 1'b0;
                    xrd_d   = 1'b0;
                    xwr_d   = 1'b0;
                    xbe_d   = 4'h0;
                    tmo_d   = '0;
                    cnt_d   = 2'd0;
                    state_d = ST_RESP;
                    if (!XDACK) begin
                        rdata_d = {24'h0, RSP_TMO};
                        last_d  = 2'd0;
                    end else if (op_q == OP_RD) begin
                        rdata_d = XATAI;
                        last_d  = 2'd3;
                    end else begin
                        rdata_d = {24'h0, RSP_ACK};
                        last_d  = 2'd0;
                    end
                end else begin
                    tmo_d = tmo_q + TOW'(1);
                end
            end

            ST_RESP: begin
                drop_d = RX_VALID;
                if (!tx_valid_q) begin
                    // First cycle in RESP: present the first byte
                    tx_valid_d = 1'b1;
                    tx_data_d  = rdata_q[7:0];
                end else if (TX_READY) begin
                    if (cnt_q == last_q) begin
                        tx_valid_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        cnt_d     = cnt_q + 2'd1;
                        rdata_d   = {8'h0, rdata_q[31:8]};
                        tx_data_d = rdata_q[15:8];
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; synchronous reset clears everything
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q    <= ST_IDLE;
            op_q       <= 8'h0;
            cnt_q      <= 2'd0;
            last_q     <= 2'd0;
            shift_q    <= 32'h0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
            tmo_q      <= '0;
            xdreq_q    <= 1'b0;
            xrd_q      <= 1'b0;
            xwr_q      <= 1'b0;
            xbe_q      <= 4'h0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h0;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            tmo_q      <= tmo_d;
            xdreq_q    <= xdreq_d;
            xrd_q      <= xrd_d;
            xwr_q      <= xwr_d;
            xbe_q      <= xbe_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
        end
    end

    assign TX_DATA  = tx_data_q;
    assign TX_VALID = tx_valid_q;
    assign XDREQ    = xdreq_q;
    assign XRD      = xrd_q;
    assign XWR      = xwr_q;
    assign XBE      = xbe_q;
    assign XADDR    = addr_q;
    assign XATAO    = wdata_q;
    assign BUSY     = busy_q;
    assign DROP     = drop_q;

endmodule

// File: tb/tb_bus_debug_master.sv
// Bench for bus_debug_master: directed commands, a bus responder/monitor
// and a TX scoreboard fed from an expected-byte queue.
module tb_bus_debug_master;

  localparam int TIMEOUT = 16;
  localparam int TOW     = 5;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wr;
    int          ack_delay;  // request cycle index that gets XDACK, -1 = never
    int          len;        // expected XDREQ high cycles, 0 = unchecked
    logic [31:0] rdata;
  } bus_txn_t;

  logic        CLK;
  logic        RES;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY;
  logic        XDREQ;
  logic        XRD;
  logic        XWR;
  logic [3:0]  XBE;
  logic [31:0] XADDR;
  logic [31:0] XATAO;
  logic [31:0] XATAI;
  logic        XDACK;
  logic        BUSY;
  logic        DROP;

  logic [7:0] exp_q[$];
  bus_txn_t   bus_exp_q[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         drop_cnt = 0;

  bus_debug_master #(.TIMEOUT(TIMEOUT), .TOW(TOW)) dut (
    .CLK(CLK), .RES(RES),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .XDREQ(XDREQ), .XRD(XRD), .XWR(XWR), .XBE(XBE),
    .XADDR(XADDR), .XATAO(XATAO), .XATAI(XATAI), .XDACK(XDACK),
    .BUSY(BUSY), .DROP(DROP)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (act=running exp=done)");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    @(negedge CLK);
    RX_VALID = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge CLK); #2;
      if (!BUSY) done = 1;
    end
    if (!done) check("idle_wait_expired", 64'd1, 64'd0);
  endtask

  // ---------------- TX scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge CLK); #1;
      if (!RES && TX_VALID && TX_READY) begin
        if (exp_q.size() == 0) check("tx_unexpected_byte", 64'(TX_DATA) | 64'h100, 64'h0);
        else check("tx_byte", 64'(TX_DATA), 64'(exp_q.pop_front()));
      end
      if (!RES && DROP) drop_cnt++;
    end
  end

  // ---------------- bus responder / monitor ----------------
  initial begin
    int       req_cyc;
    bus_txn_t cur;
    req_cyc = 0;
    cur = '{addr: 32'h0, data: 32'h0, wr: 1'b0, ack_delay: -1, len: 0, rdata: 32'h0};
    XDACK = 1'b0;
    XATAI = 32'h0;
    forever begin
      @(negedge CLK); #1;
      XDACK = 1'b0;
      XATAI = 32'h0;
      if (XDREQ) begin
        if (req_cyc == 0) begin
          if (bus_exp_q.size() == 0) begin
            check("bus_unexpected_req", 64'd1, 64'd0);
            cur = '{addr: 32'h0, data: 32'h0, wr: 1'b0, ack_delay: -1, len: 0, rdata: 32'h0};
          end else begin
            cur = bus_exp_q[0];
            check("bus_addr", 64'(XADDR), 64'(cur.addr));
            check("bus_rd_wr", {62'h0, XRD, XWR}, {62'h0, ~cur.wr, cur.wr});
            check("bus_be", 64'(XBE), 64'hF);
            if (cur.wr) check("bus_wdata", 64'(XATAO), 64'(cur.data));
          end
        end
        if (cur.ack_delay == req_cyc) begin
          XDACK = 1'b1;
          XATAI = cur.rdata;
        end
        req_cyc++;
      end else if (req_cyc != 0) begin
        if (cur.len != 0) check("bus_req_len", 64'(req_cyc), 64'(cur.len));
        check("bus_be_idle", 64'(XBE), 64'h0);
        if (bus_exp_q.size() != 0) void'(bus_exp_q.pop_front());
        req_cyc = 0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    bit seen;
    RES      = 1'b1;
    RX_DATA  = 8'h0;
    RX_VALID = 1'b0;
    TX_READY = 1'b1;
    repeat (3) @(negedge CLK);
    #2;
    check("reset_outputs", {XDREQ, XRD, XWR, XBE, TX_VALID, BUSY, DROP, TX_DATA, XADDR[15:0]}, 64'h0);
    RES = 1'b0;
    @(negedge CLK); #2;
    check("post_reset_idle", {61'h0, BUSY, XDREQ, TX_VALID}, 64'h0);

    // Write: 57,00,01,00,40,EF,BE,AD,DE, ack on the 4th request cycle
    bus_exp_q.push_back('{addr: 32'h40000100, data: 32'hDEADBEEF, wr: 1'b1,
                          ack_delay: 3, len: 4, rdata: 32'h0});
    exp_q.push_back(8'h06);
    send_byte(8'h57);
    check("busy_after_opcode", 64'(BUSY), 64'd1);
    send_word(32'h40000100);
    send_word(32'hDEADBEEF);
    wait_idle();
    check("write_resp_before_idle", 64'(exp_q.size()), 64'd0);

    // Read: 52,03,00,00,00 with ack in the first request cycle
    bus_exp_q.push_back('{addr: 32'h00000000, data: 32'h0, wr: 1'b0,
                          ack_delay: 0, len: 1, rdata: 32'h12345678});
    exp_q.push_back(8'h78); exp_q.push_back(8'h56);
    exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    send_byte(8'h52);
    send_word(32'h00000003);
    wait_idle();
    check("read_resp_done", 64'(exp_q.size()), 64'd0);

    // Timeout: read of 0xC0000000, never acknowledged
    bus_exp_q.push_back('{addr: 32'hC0000000, data: 32'h0, wr: 1'b0,
                          ack_delay: -1, len: TIMEOUT, rdata: 32'h0});
    exp_q.push_back(8'h18);
    send_byte(8'h52);
    send_word(32'hC0000000);
    wait_idle();
    check("timeout_resp_done", 64'(exp_q.size()), 64'd0);

    // Backpressure with a dropped byte during the response
    TX_READY = 1'b0;
    bus_exp_q.push_back('{addr: 32'h00000200, data: 32'h0, wr: 1'b0,
                          ack_delay: 1, len: 2, rdata: 32'h12345678});
    exp_q.push_back(8'h78); exp_q.push_back(8'h56);
    exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    send_byte(8'h52);
    send_word(32'h00000201);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge CLK); #2;
      if (TX_VALID) seen = 1;
    end
    check("bp_tx_valid_seen", 64'(seen), 64'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (i == 5) begin RX_DATA = 8'h50; RX_VALID = 1'b1; end
      if (i == 6) RX_VALID = 1'b0;
      #2;
      check("bp_tx_hold", {55'h0, TX_VALID, TX_DATA}, {55'h0, 1'b1, 8'h78});
    end
    check("bp_drop_count", 64'(drop_cnt), 64'd1);
    @(negedge CLK);
    TX_READY = 1'b1;
    wait_idle();
    check("bp_resp_done", 64'(exp_q.size()), 64'd0);

    // Unknown opcode, then ping
    exp_q.push_back(8'h15);
    send_byte(8'hAA);
    wait_idle();
    check("nak_done", 64'(exp_q.size()), 64'd0);
    exp_q.push_back(8'h50);
    send_byte(8'h50);
    wait_idle();
    check("ping_done", 64'(exp_q.size()), 64'd0);

    // Reset while the bus request is outstanding
    bus_exp_q.push_back('{addr: 32'h00000010, data: 32'h0, wr: 1'b0,
                          ack_delay: -1, len: 0, rdata: 32'h0});
    send_byte(8'h52);
    send_word(32'h00000010);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK); #2;
      if (XDREQ) seen = 1;
    end
    check("rst_req_seen", 64'(seen), 64'd1);
    repeat (2) @(negedge CLK);
    RES = 1'b1;
    @(negedge CLK);
    RES = 1'b0;
    #2;
    check("rst_mid_bus", {61'h0, XDREQ, TX_VALID, BUSY}, 64'h0);
    exp_q.push_back(8'h50);
    send_byte(8'h50);
    wait_idle();
    check("ping_after_reset", 64'(exp_q.size()), 64'd0);

    // Final drain and report
    repeat (5) @(negedge CLK);
    check("final_tx_queue_empty", 64'(exp_q.size()), 64'd0);
    check("final_bus_queue_empty", 64'(bus_exp_q.size()), 64'd0);
    check("final_drop_count", 64'(drop_cnt), 64'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
